// File: rtl/multi_rival_controller.sv
// Rival-car engine: spawns rivals into LFSR-chosen lanes, scrolls them once per frame,
// retires off-screen cars into a saturating pass counter and flags overlap with the player.
module multi_rival_controller #(
    parameter int                NUM_RIVALS = 4,
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h5A,
    parameter int                NUM_LANES  = 4,
    parameter logic [9:0]        LANE_X0    = 10'd200,
    parameter logic [9:0]        LANE_W     = 10'd60,
    parameter logic [9:0]        CAR_W      = 10'd32,
    parameter logic [9:0]        CAR_H      = 10'd48,
    parameter logic [9:0]        Y_TOP      = 10'd0,
    parameter logic [9:0]        Y_MAX      = 10'd480,
    parameter logic [9:0]        SPEED      = 10'd4,
    parameter logic [5:0]        SPAWN_GAP  = 6'd30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic                     restart,
    input  logic [9:0]               main_x,
    input  logic [9:0]               main_y,
    output logic [10*NUM_RIVALS-1:0] rival_x,
    output logic [10*NUM_RIVALS-1:0] rival_y,
    output logic [NUM_RIVALS-1:0]    rival_active,
    output logic                     collision,
    output logic [2:0]               collide_idx,
    output logic [15:0]              passed_count,
    output logic [LFSR_W-1:0]        prng_q
);

    logic [9:0]        r_x [NUM_RIVALS];
    logic [9:0]        r_y [NUM_RIVALS];
    logic [NUM_RIVALS-1:0] r_active;
    logic [5:0]        r_timer;
    logic              r_collision;
    logic [2:0]        r_collide_idx;
    logic [15:0]       r_passed;
    logic [LFSR_W-1:0] r_lfsr;

    logic [LFSR_W-1:0] w_lfsr_next;
    logic              w_step;
    logic [9:0]        w_new_y [NUM_RIVALS];
    logic [NUM_RIVALS-1:0] w_retire;
    logic [3:0]        w_retire_cnt;
    logic [16:0]       w_pass_sum;
    logic [15:0]       w_passed_next;
    logic              w_spawn_due;
    logic [5:0]        w_timer_next;
    logic              w_spawn_ok;
    logic [2:0]        w_spawn_slot;
    logic [LFSR_W-1:0] w_lane;
    logic [9:0]        w_spawn_x;
    logic [NUM_RIVALS-1:0] w_hit;
    logic              w_hit_any;
    logic [2:0]        w_hit_idx;

    // A zero state would lock the Galois register, so it is reseeded instead.
    assign w_lfsr_next = (r_lfsr == '0) ? LFSR_SEED
                       : ((r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0));

    assign w_step       = frame_tick & run & ~r_collision;
    assign w_spawn_due  = (r_timer == SPAWN_GAP - 6'd1);
    assign w_timer_next = w_spawn_due ? 6'd0 : r_timer + 6'd1;
    assign w_lane       = r_lfsr % LFSR_W'(NUM_LANES);
    assign w_spawn_x    = LANE_X0 + 10'(w_lane) * LANE_W;
    assign w_pass_sum   = 17'(r_passed) + 17'(w_retire_cnt);
    assign w_passed_next = w_pass_sum[16] ? 16'hFFFF : w_pass_sum[15:0];

    always_comb begin
        w_retire_cnt = '0;
        w_spawn_ok   = 1'b0;
        w_spawn_slot = '0;
        w_hit_idx    = '0;
        w_hit        = '0;
        w_retire     = '0;
        for (int i = 0; i < NUM_RIVALS; i++) begin
            w_new_y[i]   = r_y[i] + SPEED;
            w_retire[i]  = r_active[i] & (w_new_y[i] >= Y_MAX);
            w_retire_cnt = w_retire_cnt + 4'(w_retire[i]);
            // 11-bit compares so right/bottom edges near 1023 cannot wrap.
            w_hit[i] = r_active[i]
                     & ({1'b0, main_x} < ({1'b0, r_x[i]} + {1'b0, CAR_W}))
                     & ({1'b0, r_x[i]} < ({1'b0, main_x} + {1'b0, CAR_W}))
                     & ({1'b0, main_y} < ({1'b0, r_y[i]} + {1'b0, CAR_H}))
                     & ({1'b0, r_y[i]} < ({1'b0, main_y} + {1'b0, CAR_H}));
        end
        for (int i = NUM_RIVALS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_spawn_ok   = 1'b1;
                w_spawn_slot = 3'(i);
            end
            if (w_hit[i]) begin
                w_hit_idx = 3'(i);
            end
        end
        w_hit_any = |w_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RIVALS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_active      <= '0;
            r_timer       <= '0;
            r_collision   <= 1'b0;
            r_collide_idx <= '0;
            r_passed      <= '0;
            r_lfsr        <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (restart) begin
                for (int i = 0; i < NUM_RIVALS; i++) begin
                    r_x[i] <= '0;
                    r_y[i] <= '0;
                end
                r_active      <= '0;
                r_timer       <= '0;
                r_collision   <= 1'b0;
                r_collide_idx <= '0;
                r_passed      <= '0;
            end else begin
                if (run && !r_collision && w_hit_any) begin
                    r_collision   <= 1'b1;
                    r_collide_idx <= w_hit_idx;
                end
                if (w_step) begin
                    r_timer  <= w_timer_next;
                    r_passed <= w_passed_next;
                    // Spawn only targets slots inactive before this tick, so a car
                    // retiring now cannot be reused until the next attempt.
                    for (int i = 0; i < NUM_RIVALS; i++) begin
                        if (w_retire[i]) begin
                            r_active[i] <= 1'b0;
                            r_y[i]      <= '0;
                        end else if (r_active[i]) begin
                            r_y[i] <= w_new_y[i];
                        end else if (w_spawn_due && w_spawn_ok && (w_spawn_slot == 3'(i))) begin
                            r_active[i] <= 1'b1;
                            r_y[i]      <= Y_TOP;
                            r_x[i]      <= w_spawn_x;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rival_x = '0;
        rival_y = '0;
        for (int i = 0; i < NUM_RIVALS; i++) begin
            rival_x[10*i +: 10] = r_x[i];
            rival_y[10*i +: 10] = r_y[i];
        end
    end

    assign rival_active = r_active;
    assign collision    = r_collision;
    assign collide_idx  = r_collide_idx;
    assign passed_count = r_passed;
    assign prng_q       = r_lfsr;

endmodule

// File: tb/tb_multi_rival_controller.sv
// Directed bench for multi_rival_controller: reset, spawn cadence, retire/drop, collision,
// restart priority, run freeze and asynchronous reset, with an independent LFSR reference.
module tb_multi_rival_controller;

    localparam logic [7:0] SEED = 8'h5A;
    localparam logic [7:0] TAPS = 8'hB8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  main_x = 10'd0;
    logic [9:0]  main_y = 10'd400;
    logic [39:0] rival_x;
    logic [39:0] rival_y;
    logic [3:0]  rival_active;
    logic        collision;
    logic [2:0]  collide_idx;
    logic [15:0] passed_count;
    logic [7:0]  prng_q;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  m_lfsr;
    logic [9:0]  tick_x;
    logic [9:0]  x1_saved;

    multi_rival_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .restart(restart),
        .main_x(main_x), .main_y(main_y), .rival_x(rival_x), .rival_y(rival_y),
        .rival_active(rival_active), .collision(collision), .collide_idx(collide_idx),
        .passed_count(passed_count), .prng_q(prng_q)
    );

    always #5 clk = ~clk;

    // Reference LFSR: reseeds only on rst_n, free-runs through restart.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else if (m_lfsr == 8'h00) m_lfsr <= SEED;
        else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 8'h00);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [9:0] lane_x(input logic [7:0] q);
        case (q[1:0])
            2'd0: return 10'd200;
            2'd1: return 10'd260;
            2'd2: return 10'd320;
            default: return 10'd380;
        endcase
    endfunction

    function automatic logic [9:0] rx(input int i);
        return rival_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] ry(input int i);
        return rival_y[10*i +: 10];
    endfunction

    // Each frame: pulse frame_tick for one cycle; tick_x holds the lane x the DUT sees.
    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk);
            tick_x = lane_x(m_lfsr);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] prev;
        #2 rst_n = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rival_x, rival_y, rival_active, collision, collide_idx, passed_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got_active=%b got_coll=%b got_pass=%0d exp=0", rival_active, collision, passed_count);
        end
        n_checks++;
        if (prng_q !== SEED) begin
            n_fail++;
            $display("FAIL reset_prng got=%h exp=%h", prng_q, SEED);
        end
        rst_n = 1'b1;
        prev = prng_q;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_checks++;
            if (prng_q !== m_lfsr || prng_q === 8'h00 || prng_q === prev) begin
                n_fail++;
                $display("FAIL lfsr_step cycle=%0d got=%h exp=%h prev=%h", c, prng_q, m_lfsr, prev);
            end
            prev = prng_q;
        end
        n_checks++;
        if ({rival_y, rival_active, collision, passed_count} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs got_active=%b got_pass=%0d exp=0", rival_active, passed_count);
        end
    endtask

    task automatic test_spawn();
        main_x = 10'd0;
        main_y = 10'd400;
        run = 1'b1;
        frames(29);
        n_checks++;
        if (rival_active !== 4'b0000) begin
            n_fail++;
            $display("FAIL spawn_early got=%b exp=0000", rival_active);
        end
        frames(1);
        n_checks++;
        if (rival_active !== 4'b0001 || ry(0) !== 10'd0 || rx(0) !== tick_x) begin
            n_fail++;
            $display("FAIL spawn_slot0 got_act=%b y=%0d x=%0d exp_act=0001 y=0 x=%0d", rival_active, ry(0), rx(0), tick_x);
        end
        frames(30);
        n_checks++;
        if (rival_active !== 4'b0011 || ry(0) !== 10'd120 || ry(1) !== 10'd0 || rx(1) !== tick_x) begin
            n_fail++;
            $display("FAIL spawn_slot1 got_act=%b y0=%0d y1=%0d x1=%0d exp_act=0011 y0=120 y1=0 x1=%0d",
                     rival_active, ry(0), ry(1), rx(1), tick_x);
        end
    endtask

    task automatic test_retire();
        frames(89);
        n_checks++;
        if (rival_active !== 4'b1111 || ry(0) !== 10'd476 || passed_count !== 16'd0) begin
            n_fail++;
            $display("FAIL pre_retire got_act=%b y0=%0d pass=%0d exp_act=1111 y0=476 pass=0", rival_active, ry(0), passed_count);
        end
        frames(1);
        n_checks++;
        if (rival_active !== 4'b1110 || ry(0) !== 10'd0 || passed_count !== 16'd1) begin
            n_fail++;
            $display("FAIL retire_full_drop got_act=%b y0=%0d pass=%0d exp_act=1110 y0=0 pass=1", rival_active, ry(0), passed_count);
        end
        n_checks++;
        if (ry(1) !== 10'd360 || ry(3) !== 10'd120) begin
            n_fail++;
            $display("FAIL retire_scroll got_y1=%0d y3=%0d exp_y1=360 y3=120", ry(1), ry(3));
        end
        frames(30);
        n_checks++;
        if (rival_active !== 4'b1101 || ry(0) !== 10'd0 || rx(0) !== tick_x || passed_count !== 16'd2 || ry(2) !== 10'd360) begin
            n_fail++;
            $display("FAIL respawn_retire got_act=%b y0=%0d x0=%0d pass=%0d y2=%0d exp_act=1101 y0=0 x0=%0d pass=2 y2=360",
                     rival_active, ry(0), rx(0), passed_count, ry(2), tick_x);
        end
    endtask

    task automatic test_collision();
        pulse_restart();
        n_checks++;
        if (passed_count !== 16'd0 || rival_active !== 4'b0000) begin
            n_fail++;
            $display("FAIL restart_clear got_pass=%0d act=%b exp_pass=0 act=0000", passed_count, rival_active);
        end
        frames(60);
        x1_saved = rx(1);
        @(negedge clk);
        main_x = x1_saved + 10'd32;
        main_y = 10'd10;
        repeat (2) @(negedge clk);
        n_checks++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_x_touch got=%b exp=0", collision);
        end
        main_x = x1_saved;
        main_y = 10'd48;
        repeat (2) @(negedge clk);
        n_checks++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_y_touch got=%b exp=0", collision);
        end
        main_y = 10'd10;
        @(negedge clk);
        n_checks++;
        if (collision !== 1'b1 || collide_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL collide_hit got=%b idx=%0d exp=1 idx=1", collision, collide_idx);
        end
        main_x = 10'd0;
        main_y = 10'd400;
        frames(2);
        n_checks++;
        if (collision !== 1'b1 || collide_idx !== 3'd1 || ry(0) !== 10'd120 || ry(1) !== 10'd0 || rival_active !== 4'b0011) begin
            n_fail++;
            $display("FAIL collide_freeze got_coll=%b idx=%0d y0=%0d y1=%0d act=%b exp=1 idx=1 y0=120 y1=0 act=0011",
                     collision, collide_idx, ry(0), ry(1), rival_active);
        end
    endtask

    task automatic test_restart();
        @(negedge clk);
        restart = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        frame_tick = 1'b0;
        n_checks++;
        if (rival_active !== 4'b0000 || collision !== 1'b0 || collide_idx !== 3'd0 || ry(0) !== 10'd0 || rx(0) !== 10'd0) begin
            n_fail++;
            $display("FAIL restart_tick got_act=%b coll=%b idx=%0d y0=%0d x0=%0d exp=all zero",
                     rival_active, collision, collide_idx, ry(0), rx(0));
        end
        n_checks++;
        if (prng_q !== m_lfsr) begin
            n_fail++;
            $display("FAIL restart_lfsr got=%h exp=%h", prng_q, m_lfsr);
        end
        frames(29);
        n_checks++;
        if (rival_active !== 4'b0000) begin
            n_fail++;
            $display("FAIL restart_timer got=%b exp=0000", rival_active);
        end
        frames(1);
        n_checks++;
        if (rival_active !== 4'b0001 || rx(0) !== tick_x) begin
            n_fail++;
            $display("FAIL restart_spawn got_act=%b x0=%0d exp_act=0001 x0=%0d", rival_active, rx(0), tick_x);
        end
    endtask

    task automatic test_freeze();
        frames(10);
        run = 1'b0;
        frames(10);
        n_checks++;
        if (ry(0) !== 10'd40 || rival_active !== 4'b0001 || passed_count !== 16'd0) begin
            n_fail++;
            $display("FAIL freeze_hold got_y0=%0d act=%b pass=%0d exp_y0=40 act=0001 pass=0", ry(0), rival_active, passed_count);
        end
        run = 1'b1;
        frames(19);
        n_checks++;
        if (ry(0) !== 10'd116 || rival_active !== 4'b0001) begin
            n_fail++;
            $display("FAIL freeze_resume got_y0=%0d act=%b exp_y0=116 act=0001", ry(0), rival_active);
        end
        frames(1);
        n_checks++;
        if (ry(0) !== 10'd120 || rival_active !== 4'b0011 || rx(1) !== tick_x) begin
            n_fail++;
            $display("FAIL freeze_timer got_y0=%0d act=%b x1=%0d exp_y0=120 act=0011 x1=%0d", ry(0), rival_active, rx(1), tick_x);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        frame_tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rival_active !== 4'b0000 || ry(0) !== 10'd0 || prng_q !== SEED || passed_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset got_act=%b y0=%0d prng=%h exp_act=0000 y0=0 prng=%h", rival_active, ry(0), prng_q, SEED);
        end
        frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_retire();
        test_collision();
        test_restart();
        test_freeze();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
